// File: rtl/norm_shift_lzd_pkg.sv
// Shared FP add/sub definitions: default widths, chunk-count helper, shift directions.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package norm_shift_lzd_pkg;

    // Default significand result width, including the carry bit at the MSB
    localparam int SWR_DEF = 26;
    // Default shift-value width
    localparam int EW_DEF  = 5;
    // Default chunk width of the partial leading-zero encoders
    localparam int CH_DEF  = 8;

    // Shift direction encodings shared with the barrel shifter control
    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    // Number of CH-bit chunks needed to cover the SWR-1 mantissa bits
    function automatic int calc_nch(input int swr, input int ch);
        return (swr - 1 + ch - 1) / ch;
    endfunction

endpackage

// File: rtl/lzd_chunk.sv
// Partial leading-one encoder: flags a non-zero chunk and counts its leading zeros.
// Latency: combinational, no registers.
// Backpressure: none; pure function of the input chunk.
module lzd_chunk #(
    parameter int CH  = 8,
    parameter int LZW = 3
) (
    input  logic [CH-1:0]  chunk,
    output logic           nz,
    output logic [LZW-1:0] lz
);

    // Scan LSB to MSB so the highest set bit is the last one to write lz
    always_comb begin
        nz = |chunk;
        lz = '0;
        for (int i = 0; i < CH; i++) begin
            if (chunk[i]) begin
                lz = LZW'(CH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/norm_shift_lzd.sv
// Two-stage leading-one detector producing normalization shift amount and direction.
// Latency: a load reaches the held outputs two clock edges later; one result per cycle.
// Backpressure: none; an unacknowledged result is simply overwritten by the next one.
module norm_shift_lzd
    import norm_shift_lzd_pkg::*;
#(
    parameter int SWR = SWR_DEF,
    parameter int EW  = EW_DEF,
    parameter int CH  = CH_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic [SWR-1:0] Add_subt_result_i,
    input  logic           ack_i,
    output logic [EW-1:0]  Shift_Value_o,
    output logic           FSM_left_right_o,
    output logic           Zero_flag_o,
    output logic           done_o
);

    localparam int NCH  = calc_nch(SWR, CH);
    localparam int LZW  = (CH > 1) ? $clog2(CH) : 1;
    localparam int PADW = NCH * CH;

    // Mantissa left-aligned in the chunk grid; pad zeros sit below the LSB
    logic [PADW-1:0]          m_pad;
    logic [NCH-1:0]           nz_c;
    logic [NCH-1:0][LZW-1:0]  lz_c;

    // Stage-1 registers
    logic                     v1;
    logic                     c1;
    logic [NCH-1:0]           nz1;
    logic [NCH-1:0][LZW-1:0]  lz1;

    // Stage-2 combinational select
    logic                     any_nz;
    logic [EW-1:0]            count;

    assign m_pad = PADW'(Add_subt_result_i[SWR-2:0]) << (PADW - (SWR - 1));

    // Chunk 0 is the MSB chunk, so chunk index times CH is its bit offset
    for (genvar j = 0; j < NCH; j++) begin : g_chunk
        lzd_chunk #(
            .CH  (CH),
            .LZW (LZW)
        ) u_lzd_chunk (
            .chunk (m_pad[PADW-1-j*CH -: CH]),
            .nz    (nz_c[j]),
            .lz    (lz_c[j])
        );
    end

    // Stage 1: capture carry and per-chunk partial encodings on load
    always_ff @(posedge clk) begin
        if (rst) begin
            v1  <= 1'b0;
            c1  <= 1'b0;
            nz1 <= '0;
            lz1 <= '0;
        end else begin
            v1 <= load_i;
            if (load_i) begin
                c1  <= Add_subt_result_i[SWR-1];
                nz1 <= nz_c;
                lz1 <= lz_c;
            end
        end
    end

    // Stage 2 select: the lowest-index non-zero chunk wins, walking down so it writes last
    always_comb begin
        any_nz = |nz1;
        count  = '0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (nz1[j]) begin
                count = EW'(j * CH) + EW'(lz1[j]);
            end
        end
    end

    // Stage 2: update held outputs; a same-cycle update beats an acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            Shift_Value_o    <= '0;
            FSM_left_right_o <= 1'b0;
            Zero_flag_o      <= 1'b0;
            done_o           <= 1'b0;
        end else if (v1) begin
            done_o <= 1'b1;
            if (c1) begin
                // Carry out: one-bit right shift, mantissa field irrelevant
                FSM_left_right_o <= DIR_RIGHT;
                Shift_Value_o    <= EW'(1);
                Zero_flag_o      <= 1'b0;
            end else if (any_nz) begin
                FSM_left_right_o <= DIR_LEFT;
                Shift_Value_o    <= count;
                Zero_flag_o      <= 1'b0;
            end else begin
                FSM_left_right_o <= DIR_LEFT;
                Shift_Value_o    <= '0;
                Zero_flag_o      <= 1'b1;
            end
        end else if (ack_i) begin
            done_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_norm_shift_lzd.sv
// Self-checking bench for norm_shift_lzd at SWR=26, EW=5, CH=8.
// Latency: expected results queue at load and retire two edges later.
// Backpressure: none exercised; the DUT has none.
module tb_norm_shift_lzd;

    typedef struct packed {
        logic       dir;
        logic [4:0] shift;
        logic       zero;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        load_i;
    logic [25:0] Add_subt_result_i;
    logic        ack_i;
    logic [4:0]  Shift_Value_o;
    logic        FSM_left_right_o;
    logic        Zero_flag_o;
    logic        done_o;

    int   checks = 0;
    int   errors = 0;

    exp_t exp_q[$];
    logic pend = 1'b0;
    exp_t exp_out = '0;
    logic exp_done = 1'b0;

    norm_shift_lzd #(
        .SWR (26),
        .EW  (5),
        .CH  (8)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .load_i            (load_i),
        .Add_subt_result_i (Add_subt_result_i),
        .ack_i             (ack_i),
        .Shift_Value_o     (Shift_Value_o),
        .FSM_left_right_o  (FSM_left_right_o),
        .Zero_flag_o       (Zero_flag_o),
        .done_o            (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: carry first, then bit-serial leading-zero count over [24:0]
    function automatic exp_t model(input logic [25:0] d);
        exp_t e;
        e.dir   = 1'b1;
        e.shift = 5'd0;
        e.zero  = 1'b0;
        if (d[25]) begin
            e.dir   = 1'b0;
            e.shift = 5'd1;
        end else if (d[24:0] == 25'd0) begin
            e.zero = 1'b1;
        end else begin
            for (int i = 0; i < 25; i++) begin
                if (d[i]) e.shift = 5'(24 - i);
            end
        end
        return e;
    endfunction

    // Advance one edge, keep the scoreboard in step, sample 1 time unit later
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            pend     = 1'b0;
            exp_out  = '0;
            exp_done = 1'b0;
        end else begin
            if (pend && exp_q.size() > 0) begin
                exp_out  = exp_q.pop_front();
                exp_done = 1'b1;
            end else if (ack_i) begin
                exp_done = 1'b0;
            end
            pend = load_i;
            if (load_i) exp_q.push_back(model(Add_subt_result_i));
        end
        #1;
    endtask

    task automatic load_one(input logic [25:0] d);
        load_i            = 1'b1;
        Add_subt_result_i = d;
        tick();
        load_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; load_i = 1'b0; ack_i = 1'b0; Add_subt_result_i = '0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (Shift_Value_o !== 5'd0) begin errors++; $display("FAIL reset_shift: got %0d expected 0", Shift_Value_o); end
        checks++; if (FSM_left_right_o !== 1'b0) begin errors++; $display("FAIL reset_dir: got %b expected 0", FSM_left_right_o); end
        checks++; if (Zero_flag_o !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b expected 0", Zero_flag_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_o); end
    endtask

    task automatic test_carry();
        load_i = 1'b1; Add_subt_result_i = 26'h2000000;
        tick();
        load_i = 1'b0;
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL carry_latency_done: got %b expected 0", done_o); end
        tick();
        checks++; if (FSM_left_right_o !== 1'b0) begin errors++; $display("FAIL carry_dir: got %b expected 0", FSM_left_right_o); end
        checks++; if (Shift_Value_o !== 5'd1) begin errors++; $display("FAIL carry_shift: got %0d expected 1", Shift_Value_o); end
        checks++; if (Zero_flag_o !== 1'b0) begin errors++; $display("FAIL carry_zero: got %b expected 0", Zero_flag_o); end
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL carry_done: got %b expected 1", done_o); end
    endtask

    task automatic test_normalized();
        logic [25:0] din [3];
        logic [4:0]  sh  [3];
        din[0] = 26'h1000000; sh[0] = 5'd0;
        din[1] = 26'h0000001; sh[1] = 5'd24;
        din[2] = 26'h0000080; sh[2] = 5'd17;
        for (int k = 0; k < 3; k++) begin
            load_one(din[k]);
            checks++; if (FSM_left_right_o !== 1'b1) begin errors++; $display("FAIL norm_dir[%0d]: got %b expected 1", k, FSM_left_right_o); end
            checks++; if (Shift_Value_o !== sh[k]) begin errors++; $display("FAIL norm_shift[%0d]: got %0d expected %0d", k, Shift_Value_o, sh[k]); end
            checks++; if (Zero_flag_o !== 1'b0) begin errors++; $display("FAIL norm_zero[%0d]: got %b expected 0", k, Zero_flag_o); end
        end
    endtask

    task automatic test_zero();
        load_one(26'h0000000);
        checks++; if (Zero_flag_o !== 1'b1) begin errors++; $display("FAIL zero_flag: got %b expected 1", Zero_flag_o); end
        checks++; if (Shift_Value_o !== 5'd0) begin errors++; $display("FAIL zero_shift: got %0d expected 0", Shift_Value_o); end
        checks++; if (FSM_left_right_o !== 1'b1) begin errors++; $display("FAIL zero_dir: got %b expected 1", FSM_left_right_o); end
        load_one(26'h3FFFFFF);
        checks++; if (FSM_left_right_o !== 1'b0) begin errors++; $display("FAIL allones_dir: got %b expected 0", FSM_left_right_o); end
        checks++; if (Shift_Value_o !== 5'd1) begin errors++; $display("FAIL allones_shift: got %0d expected 1", Shift_Value_o); end
        checks++; if (Zero_flag_o !== 1'b0) begin errors++; $display("FAIL allones_zero: got %b expected 0", Zero_flag_o); end
    endtask

    task automatic test_back_to_back();
        logic [25:0] din [4];
        logic [4:0]  sh  [4];
        logic        dr  [4];
        din[0] = 26'h0800000; sh[0] = 5'd1;  dr[0] = 1'b1;
        din[1] = 26'h0004000; sh[1] = 5'd10; dr[1] = 1'b1;
        din[2] = 26'h0000002; sh[2] = 5'd23; dr[2] = 1'b1;
        din[3] = 26'h2000001; sh[3] = 5'd1;  dr[3] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            load_i = (k < 4);
            if (k < 4) Add_subt_result_i = din[k];
            tick();
            if (k >= 1 && k <= 4) begin
                checks++; if (Shift_Value_o !== sh[k-1]) begin errors++; $display("FAIL b2b_shift[%0d]: got %0d expected %0d", k-1, Shift_Value_o, sh[k-1]); end
                checks++; if (FSM_left_right_o !== dr[k-1]) begin errors++; $display("FAIL b2b_dir[%0d]: got %b expected %b", k-1, FSM_left_right_o, dr[k-1]); end
                checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL b2b_done[%0d]: got %b expected 1", k-1, done_o); end
            end
            if (k == 5) begin
                checks++; if (Shift_Value_o !== 5'd1 || FSM_left_right_o !== 1'b0) begin errors++; $display("FAIL b2b_hold: got shift %0d dir %b expected shift 1 dir 0", Shift_Value_o, FSM_left_right_o); end
            end
        end
        load_i = 1'b0;
    endtask

    task automatic test_handshake();
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL ack_clear: got %b expected 0", done_o); end
        load_i = 1'b1; Add_subt_result_i = 26'h0000100;
        tick();
        load_i = 1'b0; ack_i = 1'b1;
        tick();
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL ack_vs_update: got %b expected 1", done_o); end
        checks++; if (Shift_Value_o !== 5'd16) begin errors++; $display("FAIL ack_update_shift: got %0d expected 16", Shift_Value_o); end
        tick();
        ack_i = 1'b0;
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL ack_late_clear: got %b expected 0", done_o); end
    endtask

    task automatic test_reset_inflight();
        load_one(26'h0000001);
        load_i = 1'b1; Add_subt_result_i = 26'h0000004;
        tick();
        rst = 1'b1; load_i = 1'b1; Add_subt_result_i = 26'h2000000;
        tick();
        checks++; if ({Shift_Value_o, FSM_left_right_o, Zero_flag_o, done_o} !== 8'd0) begin errors++; $display("FAIL rst_inflight_now: got %h expected 0", {Shift_Value_o, FSM_left_right_o, Zero_flag_o, done_o}); end
        rst = 1'b0; load_i = 1'b0;
        tick();
        checks++; if ({Shift_Value_o, FSM_left_right_o, Zero_flag_o, done_o} !== 8'd0) begin errors++; $display("FAIL rst_inflight_after: got %h expected 0", {Shift_Value_o, FSM_left_right_o, Zero_flag_o, done_o}); end
        tick();
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rst_load_ignored: got %b expected 0", done_o); end
    endtask

    task automatic test_random();
        int          nloads = 0;
        int          cyc    = 0;
        logic [31:0] r;
        while (nloads < 10000 && cyc < 40000) begin
            cyc++;
            rst    = ($urandom_range(0, 99) == 0);
            load_i = ($urandom_range(0, 9) < 7);
            ack_i  = ($urandom_range(0, 4) == 0);
            r      = $urandom;
            Add_subt_result_i = r[25:0] >> $urandom_range(0, 26);
            if (load_i && !rst) nloads++;
            tick();
            checks++; if (Shift_Value_o !== exp_out.shift) begin errors++; $display("FAIL rand_shift cyc %0d: got %0d expected %0d", cyc, Shift_Value_o, exp_out.shift); end
            checks++; if (FSM_left_right_o !== exp_out.dir) begin errors++; $display("FAIL rand_dir cyc %0d: got %b expected %b", cyc, FSM_left_right_o, exp_out.dir); end
            checks++; if (Zero_flag_o !== exp_out.zero) begin errors++; $display("FAIL rand_zero cyc %0d: got %b expected %b", cyc, Zero_flag_o, exp_out.zero); end
            checks++; if (done_o !== exp_done) begin errors++; $display("FAIL rand_done cyc %0d: got %b expected %b", cyc, done_o, exp_done); end
        end
        checks++; if (nloads < 10000) begin errors++; $display("FAIL rand_budget: got %0d loads expected 10000", nloads); end
        rst = 1'b0; load_i = 1'b0; ack_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_carry();
        test_normalized();
        test_zero();
        test_back_to_back();
        test_handshake();
        test_reset_inflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/norm_shift_lzd.md
# norm_shift_lzd

Two-stage pipelined leading-one detector for the FP add/subtract normalization step. It takes the SWR-bit significand result of the adder and produces the shift amount and direction for the barrel shifter (`Mux_Array`), which performs the normalization shift. Outputs are registered and held until the next result, so the control FSM can sample them at any later cycle.

## Interface
Parameters:
- `SWR`, 26: significand result width, including the carry/overflow bit at `SWR-1`.
- `EW`, 5: shift-value width. The legal configuration requires 2^EW > SWR-2.
- `CH`, 8: chunk width for the stage-1 partial encoders. Must be a power of two.

Ports:
- `clk`, input, 1: clock. Single clock domain.
- `rst`, input, 1: synchronous, active-high reset.
- `load_i`, input, 1: sample `Add_subt_result_i` this cycle.
- `Add_subt_result_i`, input, SWR: adder result. Bit `SWR-1` is the carry.
- `ack_i`, input, 1: clears `done_o`.
- `Shift_Value_o`, output, EW: normalization shift amount.
- `FSM_left_right_o`, output, 1: shift direction. 1 = left, 0 = right.
- `Zero_flag_o`, output, 1: the result bits `[SWR-2:0]` were all zero and there was no carry.
- `done_o`, output, 1: a new result is held on the outputs.

## Operation
- **Stage 1 (S1), on `load_i`:**
  - Register the carry bit `c = Add_subt_result_i[SWR-1]`.
  - Take the mantissa field `m = Add_subt_result_i[SWR-2:0]` and zero-pad it at the LSB end to `NCH*CH` bits, where `NCH = ceil((SWR-1)/CH)`.
  - For each chunk j (chunk 0 = MSB chunk), register `nz[j]` (OR of the chunk) and `lz[j]` (leading-zero count within the chunk, log2(CH) bits).
  - Set `v1 = 1`.
- **Stage 2 (S2), when `v1` = 1:**
  - Find the first chunk j with `nz[j]` = 1. Then `count = j*CH + lz[j]`.
  - If `c` = 1: `FSM_left_right_o` = 0, `Shift_Value_o` = 1, `Zero_flag_o` = 0. Carry has priority; the mantissa field is ignored.
  - Else if any `nz` is set: `FSM_left_right_o` = 1, `Shift_Value_o = count`. `count` is never above SWR-2, because pad bits are never reached.
  - Else: `Zero_flag_o` = 1, `Shift_Value_o` = 0, `FSM_left_right_o` = 1.
  - Set `done_o` = 1.
- **Output hold:** outputs are stable until the next S2 update or until reset.
- **`done_o`:**
  - Set by an S2 update.
  - Cleared by `ack_i` when there is no S2 update that cycle.
  - If an S2 update and `ack_i` occur in the same cycle, the update wins and `done_o` stays 1.
- **Throughput:** fully pipelined. `load_i` can be asserted every cycle, and there is no backpressure. If `done_o` is still 1 when a new result lands, the held value is overwritten; no error is flagged.
- **Reset:**
  - Clears `v1`, all S1 registers, `Shift_Value_o` (0), `FSM_left_right_o` (0), `Zero_flag_o` (0) and `done_o` (0).
  - A reset while a load is in flight discards it.
  - `load_i` in the reset cycle is ignored.

## Timing
- Latency: a `load_i` at edge N updates the outputs and sets `done_o` at edge N+2.
- `v1` is a single-cycle flag. `v1` = 1 at N+1 only if `load_i` was high at N.
- Back-to-back loads at N and N+1 produce updates at N+2 and N+3 with no bubble.
- There is no combinational path from any input to any output.
- Critical path: the S2 first-nonzero-chunk priority select followed by a `j*CH` shift-add over NCH = 4 chunks (at SWR = 26).

## Structure
- Shared FP add/sub package holds:
  - the `SWR`/`EW` defaults,
  - a derived `NCH` function,
  - the direction encodings `DIR_LEFT` = 1 and `DIR_RIGHT` = 0, used by both this block and the shifter's control.
- One sub-module, `lzd_chunk`: combinational, CH bits in, `{nz, lz}` out. It is instantiated NCH times in a generate loop in S1.

## Test plan
All scenarios use SWR = 26, EW = 5, CH = 8.
- **Carry:** load `26'h2000000` -> at +2, right (0), shift 1, zero 0, `done_o` 1.
- **Already normalized:** load `26'h1000000` -> left (1), shift 0. Load `26'h0000001` -> left, shift 24. Load `26'h0000080` -> left, shift 17.
- **All zero:** load `26'h0000000` -> `Zero_flag_o` 1, shift 0. Then load `26'h3FFFFFF` -> carry has priority: right, shift 1, zero 0.
- **Back-to-back:** loads on 4 consecutive cycles of `26'h0800000`, `26'h0004000`, `26'h0000002`, `26'h2000001` -> shifts 1, 10, 23, 1 (directions L, L, L, R) on consecutive cycles starting at +2. Outputs hold the last value afterwards.
- **Handshake and reset:**
  - `ack_i` one cycle after `done_o` -> `done_o` drops the next edge.
  - `ack_i` together with an S2 update -> `done_o` stays 1.
  - Assert `rst` one cycle after `load_i` -> no update; all outputs 0 on the next edge.
- **Random:** 10k random loads checked against a reference model (priority `c`, then leading-zero count over bits [24:0]), including random `ack_i`/`rst`.
